fractal_pixel_scheduler: RTL and testbench

FRACTAL_PIXEL_SCHEDULER -- requirements
Module: fractal_pixel_scheduler

---
 rtl/fractal_pixel_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_fractal_pixel_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_pixel_scheduler.sv
// fractal_pixel_scheduler: deals raster pixel jobs round-robin to N_ENG
// iteration engines and re-serialises their results in raster order.
// Ports: out_stream_aclk / periph_reset  clock, synchronous active-high reset
//        start, busy, frame_done         frame control and status
//        eng_req_*                       job dispatch (one-hot valid, shared x/y)
//        eng_res_*                       result collection (one-hot ready)
//        pix_*                           raster result stream with sof/eol
module fractal_pixel_scheduler #(
   parameter int N_ENG  = 4,
   parameter int X_SIZE = 1920,
   parameter int Y_SIZE = 1080
) (
   input  logic               out_stream_aclk,
   input  logic               periph_reset,
   input  logic               start,
   output logic               busy,
   output logic               frame_done,
   output logic [N_ENG-1:0]   eng_req_valid,
   input  logic [N_ENG-1:0]   eng_req_ready,
   output logic [15:0]        eng_req_x,
   output logic [15:0]        eng_req_y,
   input  logic [N_ENG-1:0]   eng_res_valid,
   output logic [N_ENG-1:0]   eng_res_ready,
   input  logic [8*N_ENG-1:0] eng_res_iter,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [7:0]         pix_iter,
   output logic               pix_sof,
   output logic               pix_eol
);

   localparam int PW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(N_ENG - 1);
   localparam logic [15:0] X_LAST = 16'(X_SIZE - 1);
   localparam logic [15:0] Y_LAST = 16'(Y_SIZE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state;

   logic [N_ENG-1:0] inflight;
   logic [PW-1:0]    dsp_ptr;
   logic [PW-1:0]    ret_ptr;
   logic [15:0]      dsp_x;
   logic [15:0]      dsp_y;
   logic [15:0]      ret_x;
   logic [15:0]      ret_y;
   logic             pix_last;

   logic [N_ENG-1:0] dsp_onehot;
   logic [N_ENG-1:0] ret_onehot;
   logic [7:0]       res_sel;
   logic             dsp_free;
   logic             ret_busy;
   logic             out_free;
   logic             active;
   logic             req_fire;
   logic             res_fire;
   logic             pix_fire;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      dsp_onehot = '0;
      ret_onehot = '0;
      res_sel    = '0;
      for (int k = 0; k < N_ENG; k++) begin
         if (dsp_ptr == PW'(k)) begin
            dsp_onehot[k] = 1'b1;
         end
         if (ret_ptr == PW'(k)) begin
            ret_onehot[k] = 1'b1;
            res_sel       = eng_res_iter[8*k +: 8];
         end
      end
   end

   assign dsp_free = ~|(inflight & dsp_onehot);
   assign ret_busy = |(inflight & ret_onehot);
   assign out_free = ~pix_valid | pix_ready;
   assign active   = (state == RUN) || (state == DRAIN);

   // Gating with reset keeps every handshake dead while reset is held,
   // so no job or result can slip through the reset cycle.
   assign eng_req_valid = (state == RUN && !periph_reset && dsp_free)
                          ? dsp_onehot : '0;
   assign eng_res_ready = (active && !periph_reset && ret_busy && out_free)
                          ? ret_onehot : '0;

   assign eng_req_x = dsp_x;
   assign eng_req_y = dsp_y;

   assign req_fire = |(eng_req_valid & eng_req_ready);
   assign res_fire = |(eng_res_ready & eng_res_valid);
   assign pix_fire = pix_valid & pix_ready;

   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         inflight   <= '0;
         dsp_ptr    <= '0;
         ret_ptr    <= '0;
         dsp_x      <= '0;
         dsp_y      <= '0;
         ret_x      <= '0;
         ret_y      <= '0;
         pix_valid  <= 1'b0;
         pix_iter   <= '0;
         pix_sof    <= 1'b0;
         pix_eol    <= 1'b0;
         pix_last   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  dsp_ptr <= '0;
                  ret_ptr <= '0;
                  dsp_x   <= '0;
                  dsp_y   <= '0;
                  ret_x   <= '0;
                  ret_y   <= '0;
               end
            end
            RUN: begin
               if (req_fire && dsp_x == X_LAST && dsp_y == Y_LAST) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pix_fire && pix_last) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // An engine cannot be dispatched and retired in the same cycle:
         // dispatch needs its inflight bit clear, retire needs it set.
         inflight <= (inflight | (req_fire ? dsp_onehot : '0))
                     & ~(res_fire ? ret_onehot : '0);

         if (req_fire) begin
            dsp_ptr <= ptr_next(dsp_ptr);
            if (dsp_x == X_LAST) begin
               dsp_x <= '0;
               dsp_y <= (dsp_y == Y_LAST) ? '0 : dsp_y + 16'd1;
            end else begin
               dsp_x <= dsp_x + 16'd1;
            end
         end

         if (res_fire) begin
            pix_valid <= 1'b1;
            pix_iter  <= res_sel;
            pix_sof   <= (ret_x == '0) && (ret_y == '0);
            pix_eol   <= (ret_x == X_LAST);
            pix_last  <= (ret_x == X_LAST) && (ret_y == Y_LAST);
            ret_ptr   <= ptr_next(ret_ptr);
            if (ret_x == X_LAST) begin
               ret_x <= '0;
               ret_y <= (ret_y == Y_LAST) ? '0 : ret_y + 16'd1;
            end else begin
               ret_x <= ret_x + 16'd1;
            end
         end else if (pix_fire) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// tb_fractal_pixel_scheduler: drives a 4x2 frame through a two-engine and a
// one-engine scheduler against behavioural engines and a raster model.
module tb_fractal_pixel_scheduler;

   localparam int XS   = 4;
   localparam int YS   = 2;
   localparam int NPIX = XS * YS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       pix_ready;
   logic [1:0] start;

   logic [1:0]  res_valid [2];
   logic [15:0] res_iter  [2];

   logic        busy0, fd0, pv0, sof0, eol0;
   logic [7:0]  it0;
   logic [1:0]  rv0, rr0;
   logic [15:0] x0, y0;

   logic        busy1, fd1, pv1, sof1, eol1;
   logic [7:0]  it1;
   logic        rv1, rr1;
   logic [15:0] x1, y1;

   fractal_pixel_scheduler #(.N_ENG(2), .X_SIZE(XS), .Y_SIZE(YS)) dut0 (
      .out_stream_aclk (clk),
      .periph_reset    (rst),
      .start           (start[0]),
      .busy            (busy0),
      .frame_done      (fd0),
      .eng_req_valid   (rv0),
      .eng_req_ready   (2'b11),
      .eng_req_x       (x0),
      .eng_req_y       (y0),
      .eng_res_valid   (res_valid[0]),
      .eng_res_ready   (rr0),
      .eng_res_iter    (res_iter[0]),
      .pix_valid       (pv0),
      .pix_ready       (pix_ready),
      .pix_iter        (it0),
      .pix_sof         (sof0),
      .pix_eol         (eol0)
   );

   fractal_pixel_scheduler #(.N_ENG(1), .X_SIZE(XS), .Y_SIZE(YS)) dut1 (
      .out_stream_aclk (clk),
      .periph_reset    (rst),
      .start           (start[1]),
      .busy            (busy1),
      .frame_done      (fd1),
      .eng_req_valid   (rv1),
      .eng_req_ready   (1'b1),
      .eng_req_x       (x1),
      .eng_req_y       (y1),
      .eng_res_valid   (res_valid[1][0:0]),
      .eng_res_ready   (rr1),
      .eng_res_iter    (res_iter[1][7:0]),
      .pix_valid       (pv1),
      .pix_ready       (pix_ready),
      .pix_iter        (it1),
      .pix_sof         (sof1),
      .pix_eol         (eol1)
   );

   int tests = 0;
   int fails = 0;
   int lat_mode;

   // snapshot of both DUTs taken at the last falling edge
   logic        s_busy [2];
   logic        s_fd   [2];
   logic        s_pv   [2];
   logic        s_sof  [2];
   logic        s_eol  [2];
   logic [7:0]  s_iter [2];
   logic [1:0]  s_reqv [2];
   logic [1:0]  s_resr [2];
   logic [15:0] s_x    [2];
   logic [15:0] s_y    [2];

   // engine models and raster scoreboard
   bit         has_job [2][2];
   int         cnt     [2][2];
   int         jx      [2][2];
   int         jy      [2][2];
   logic [1:0] req_hs  [2];
   logic [1:0] res_hs  [2];
   bit         rst_s;
   int         p       [2];
   int         dptr    [2];
   int         frames  [2];
   int         stalls  [2];
   int         e1_wait;
   bit         held_v  [2];
   logic [7:0] held_it [2];
   logic       held_sf [2];
   logic       held_el [2];
   logic [7:0] obs_it  [2][NPIX];
   logic       obs_sf  [2][NPIX];
   logic       obs_el  [2][NPIX];

   function automatic logic [7:0] fval(int x, int y);
      return 8'((x * 37 + y * 91 + 5) & 255);
   endfunction

   function automatic int ne(int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic int lat(int k);
      if (lat_mode == 1) return (k == 0) ? 10 : 2;
      if (lat_mode == 2) return int'($urandom_range(1, 50));
      return 3;
   endfunction

   task automatic chk(string name, longint act, longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic sample();
      s_busy[0] = busy0;  s_busy[1] = busy1;
      s_fd[0]   = fd0;    s_fd[1]   = fd1;
      s_pv[0]   = pv0;    s_pv[1]   = pv1;
      s_sof[0]  = sof0;   s_sof[1]  = sof1;
      s_eol[0]  = eol0;   s_eol[1]  = eol1;
      s_iter[0] = it0;    s_iter[1] = it1;
      s_reqv[0] = rv0;    s_reqv[1] = {1'b0, rv1};
      s_resr[0] = rr0;    s_resr[1] = {1'b0, rr1};
      s_x[0]    = x0;     s_x[1]    = x1;
      s_y[0]    = y0;     s_y[1]    = y1;
      rst_s = rst;
      for (int d = 0; d < 2; d++) begin
         req_hs[d] = '0;
         res_hs[d] = '0;
         if (!rst) begin
            chk("req_onehot", $countones(s_reqv[d]) <= 1, 1);
            chk("res_onehot", $countones(s_resr[d]) <= 1, 1);
            for (int k = 0; k < ne(d); k++) begin
               if (s_reqv[d][k]) chk("job_while_inflight", has_job[d][k], 0);
            end
            req_hs[d] = s_reqv[d];
            res_hs[d] = s_resr[d] & res_valid[d];
            if (d == 0 && res_valid[0][1] && !s_resr[0][1]) e1_wait++;
            if (|req_hs[d]) begin
               chk("req_x", s_x[d], dptr[d] % XS);
               chk("req_y", s_y[d], dptr[d] / XS);
               dptr[d] = (dptr[d] + 1) % NPIX;
            end
            if (held_v[d]) begin
               chk("hold_valid", s_pv[d], 1);
               chk("hold_iter", s_iter[d], held_it[d]);
               chk("hold_sof", s_sof[d], held_sf[d]);
               chk("hold_eol", s_eol[d], held_el[d]);
            end
            if (s_pv[d] && !pix_ready) begin
               chk("stall_res_ready", s_resr[d], 0);
               stalls[d]++;
            end
            held_v[d]  = s_pv[d] && !pix_ready;
            held_it[d] = s_iter[d];
            held_sf[d] = s_sof[d];
            held_el[d] = s_eol[d];
            if (s_pv[d] && pix_ready) begin
               if (p[d] < NPIX) begin
                  chk("pix_iter", s_iter[d], fval(p[d] % XS, p[d] / XS));
                  chk("pix_sof", s_sof[d], p[d] == 0);
                  chk("pix_eol", s_eol[d], (p[d] % XS) == XS - 1);
                  obs_it[d][p[d]] = s_iter[d];
                  obs_sf[d][p[d]] = s_sof[d];
                  obs_el[d][p[d]] = s_eol[d];
               end else begin
                  chk("extra_pixel", p[d], NPIX - 1);
               end
               p[d]++;
            end
            if (s_fd[d]) begin
               chk("frame_pixels", p[d], NPIX);
               p[d] = 0;
               frames[d]++;
            end
         end
      end
   endtask

   task automatic update();
      for (int d = 0; d < 2; d++) begin
         if (rst_s) begin
            p[d]      = 0;
            dptr[d]   = 0;
            held_v[d] = 0;
         end
         for (int k = 0; k < ne(d); k++) begin
            if (rst_s) begin
               has_job[d][k]   = 0;
               res_valid[d][k] = 1'b0;
               cnt[d][k]       = 0;
            end else begin
               if (res_hs[d][k]) begin
                  has_job[d][k]   = 0;
                  res_valid[d][k] = 1'b0;
               end
               if (req_hs[d][k]) begin
                  has_job[d][k] = 1;
                  jx[d][k]      = int'(s_x[d]);
                  jy[d][k]      = int'(s_y[d]);
                  cnt[d][k]     = lat(k);
               end else if (has_job[d][k] && !res_valid[d][k]) begin
                  if (cnt[d][k] <= 1) begin
                     res_valid[d][k]         = 1'b1;
                     res_iter[d][8*k +: 8]   = fval(jx[d][k], jy[d][k]);
                  end else begin
                     cnt[d][k]--;
                  end
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      update();
   endtask

   task automatic start_frame(int d);
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      tick();
      chk("start_busy", s_busy[d], 1);
      chk("start_to_req", s_reqv[d] != 0, 1);
   endtask

   task automatic wait_frame(int d);
      int f0;
      f0 = frames[d];
      for (int n = 0; n < 3000 && frames[d] == f0; n++) tick();
      if (frames[d] == f0) chk("frame_timeout", 0, 1);
      else chk("busy_at_done", s_busy[d], 0);
   endtask

   initial begin
      int f0;
      int w0;
      rst       = 1'b1;
      start     = '0;
      pix_ready = 1'b1;
      lat_mode  = 0;
      e1_wait   = 0;
      for (int d = 0; d < 2; d++) begin
         res_valid[d] = '0;
         res_iter[d]  = '0;
         p[d] = 0; dptr[d] = 0; frames[d] = 0; stalls[d] = 0; held_v[d] = 0;
         for (int k = 0; k < 2; k++) begin
            has_job[d][k] = 0; cnt[d][k] = 0; jx[d][k] = 0; jy[d][k] = 0;
         end
      end
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", s_busy[d], 0);
         chk("rst_done", s_fd[d], 0);
         chk("rst_pix_valid", s_pv[d], 0);
         chk("rst_req_valid", s_reqv[d], 0);
         chk("rst_res_ready", s_resr[d], 0);
      end
      rst = 1'b0;
      tick();

      // basic frame, fixed latency 3
      start_frame(0);
      wait_frame(0);
      chk("frames_basic", frames[0], 1);
      chk("pin_p0_iter", obs_it[0][0], 5);
      chk("pin_p0_sof", obs_sf[0][0], 1);
      chk("pin_p1_sof", obs_sf[0][1], 0);
      chk("pin_p2_eol", obs_el[0][2], 0);
      chk("pin_p3_iter", obs_it[0][3], 116);
      chk("pin_p3_eol", obs_el[0][3], 1);
      chk("pin_p7_iter", obs_it[0][7], 207);
      chk("pin_p7_eol", obs_el[0][7], 1);
      repeat (3) tick();
      chk("idle_busy", s_busy[0], 0);

      // engine 1 finishes before engine 0
      lat_mode = 1;
      w0 = e1_wait;
      start_frame(0);
      wait_frame(0);
      chk("e1_result_held", e1_wait - w0 > 0, 1);
      chk("order_p0", obs_it[0][0], 5);
      chk("order_p1", obs_it[0][1], 42);

      // output stall for 5 cycles
      lat_mode = 0;
      w0 = stalls[0];
      start_frame(0);
      for (int n = 0; n < 200 && !s_pv[0]; n++) tick();
      pix_ready = 1'b0;
      repeat (5) tick();
      pix_ready = 1'b1;
      wait_frame(0);
      chk("stall_seen", stalls[0] - w0 > 0, 1);

      // start during RUN is ignored
      f0 = frames[0];
      start_frame(0);
      repeat (4) tick();
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      wait_frame(0);
      repeat (20) tick();
      chk("one_frame_done", frames[0] - f0, 1);
      chk("busy_after_extra", s_busy[0], 0);

      // reset after 3 pixels, then a full frame
      f0 = frames[0];
      start_frame(0);
      for (int n = 0; n < 200 && p[0] < 3; n++) tick();
      chk("reached_3_pixels", p[0] >= 3, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_busy", s_busy[0], 0);
      chk("mid_rst_pix_valid", s_pv[0], 0);
      chk("mid_rst_req_valid", s_reqv[0], 0);
      chk("mid_rst_res_ready", s_resr[0], 0);
      chk("mid_rst_done", s_fd[0], 0);
      chk("mid_rst_no_frame", frames[0], f0);
      start_frame(0);
      wait_frame(0);
      chk("post_rst_frame", frames[0] - f0, 1);
      chk("post_rst_sof", obs_sf[0][0], 1);

      // single engine, random latency
      lat_mode = 2;
      start_frame(1);
      wait_frame(1);
      chk("ne1_frames", frames[1], 1);
      chk("ne1_p3_eol", obs_el[1][3], 1);
      chk("ne1_p7_iter", obs_it[1][7], 207);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
